// File: rtl/pattern_gen.sv
// Pattern generator for exercising a small gate network.
// Drives three binary-weighted stimulus clocks (clk1/clk2/clk3 = phase
// counter bits), samples the network response every RUN cycle and
// compresses it into an 8-bit signature plus a saturating ones count.
//
// state | meaning
// IDLE  | waiting for start; stimulus low, results held
// RUN   | stepping phase, sampling resp, compressing
// DONE  | one-cycle completion state; done pulses here
`timescale 1ns/1ps

module pattern_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cycles,
    input  logic       resp,
    output logic       clk1,
    output logic       clk2,
    output logic       clk3,
    output logic       busy,
    output logic       done,
    output logic [7:0] sig,
    output logic [7:0] ones
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SIG_POLY = 8'h1D;

    state_t     r_state;
    logic [2:0] r_ph;
    logic [7:0] r_cnt;
    logic [7:0] r_sig;
    logic [7:0] r_ones;
    logic       r_busy;
    logic       r_done;

    state_t     w_state_nxt;
    logic [2:0] w_ph_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_sig_nxt;
    logic [7:0] w_ones_nxt;

    // Next-state and datapath: phase stepping, period down-count, compression
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = r_cnt;
        w_sig_nxt   = r_sig;
        w_ones_nxt  = r_ones;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_nxt   = cycles;
                    w_ph_nxt    = 3'd0;
                    w_sig_nxt   = 8'h00;
                    w_ones_nxt  = 8'h00;
                    w_state_nxt = (cycles == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // The sample taken on this edge is compressed even when the
                // run is being aborted on the same edge.
                w_sig_nxt  = {r_sig[6:0], 1'b0}
                           ^ (r_sig[7] ? SIG_POLY : 8'h00)
                           ^ {7'b0, resp};
                w_ones_nxt = (r_ones == 8'hFF) ? r_ones : r_ones + {7'b0, resp};
                w_ph_nxt   = r_ph + 3'd1;
                if (r_ph == 3'd7) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = DONE;
                    end
                end
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_ph_nxt    = 3'd0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_ph_nxt    = 3'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ph_nxt    = 3'd0;
            end
        endcase
    end

    // State, datapath and registered status decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ph    <= 3'd0;
            r_cnt   <= 8'd0;
            r_sig   <= 8'h00;
            r_ones  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sig   <= w_sig_nxt;
            r_ones  <= w_ones_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign clk1 = r_ph[0];
    assign clk2 = r_ph[1];
    assign clk3 = r_ph[2];
    assign busy = r_busy;
    assign done = r_done;
    assign sig  = r_sig;
    assign ones = r_ones;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed scenarios plus randomized
// runs, each checked against a run-level reference model.
`timescale 1ns/1ps

module tb_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cycles = 8'd0;
    logic       resp = 1'b0;
    logic       clk1, clk2, clk3, busy, done;
    logic [7:0] sig, ones;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cycles(cycles), .resp(resp),
        .clk1(clk1), .clk2(clk2), .clk3(clk3),
        .busy(busy), .done(done), .sig(sig), .ones(ones)
    );

    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic r);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, r};
    endfunction

    // One complete run. mode: 0 resp=0, 1 resp=1, 2 resp=clk1 loopback, 3 random.
    // abort_at < 0 means no abort; poke_start pulses start randomly while busy
    // and once in DONE.
    task automatic do_run(input int n, input int mode, input int abort_at,
                          input bit poke_start, input string name);
        int         total;
        bit         aborted;
        logic       r;
        logic [7:0] ms;
        int         mo;
        total   = 8 * n;
        aborted = 0;
        ms      = 8'h00;
        mo      = 0;
        @(negedge clk);
        cycles = n[7:0];
        start  = 1'b1;
        abort  = 1'b1;
        resp   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        if (n == 0) begin
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b1 || sig !== 8'h00 || ones !== 8'h00) begin
                n_fail++;
                $display("FAIL %s zero_start: busy=%b done=%b sig=%h ones=%h, want busy=0 done=1 sig=00 ones=00",
                         name, busy, done, sig, ones);
            end
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s zero_after: busy=%b done=%b, want 0 0", name, busy, done);
            end
            return;
        end
        for (int k = 0; k < total && !aborted; k++) begin
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0 || {clk3, clk2, clk1} !== 3'(k % 8)) begin
                n_fail++;
                $display("FAIL %s run k=%0d: busy=%b done=%b clks=%0d, want busy=1 done=0 clks=%0d",
                         name, k, busy, done, {clk3, clk2, clk1}, k % 8);
            end
            case (mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = k[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            resp = (mode == 2) ? clk1 : r;
            if (k == abort_at) begin
                abort   = 1'b1;
                aborted = 1;
            end
            if (poke_start) start = 1'($urandom_range(0, 1));
            ms = sig_step(ms, r);
            if (mo < 255) mo = mo + int'(r);
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end
        n_tests++;
        if (sig !== ms || ones !== mo[7:0]) begin
            n_fail++;
            $display("FAIL %s result: sig=%h ones=%h, want sig=%h ones=%h", name, sig, ones, ms, mo[7:0]);
        end
        n_tests++;
        if (busy !== 1'b0 || {clk3, clk2, clk1} !== 3'd0 || done !== !aborted) begin
            n_fail++;
            $display("FAIL %s end: busy=%b clks=%0d done=%b, want busy=0 clks=0 done=%b",
                     name, busy, {clk3, clk2, clk1}, done, !aborted);
        end
        if (poke_start && !aborted) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || {clk3, clk2, clk1} !== 3'd0 ||
            sig !== ms || ones !== mo[7:0]) begin
            n_fail++;
            $display("FAIL %s hold: busy=%b done=%b clks=%0d sig=%h ones=%h, want 0 0 0 %h %h",
                     name, busy, done, {clk3, clk2, clk1}, sig, ones, ms, mo[7:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({clk3, clk2, clk1, busy, done} !== 5'b0 || sig !== 8'h00 || ones !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: clks=%0d busy=%b done=%b sig=%h ones=%h, want all 0",
                     {clk3, clk2, clk1}, busy, done, sig, ones);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic check_const(input string name, input logic [7:0] es, input logic [7:0] eo);
        n_tests++;
        if (sig !== es || ones !== eo) begin
            n_fail++;
            $display("FAIL %s const: sig=%h ones=%h, want sig=%h ones=%h", name, sig, ones, es, eo);
        end
    endtask

    task automatic test_resp_zero();
        do_run(1, 0, -1, 0, "resp0");
        check_const("resp0", 8'h00, 8'h00);
    endtask

    task automatic test_resp_one();
        do_run(1, 1, -1, 0, "resp1");
        check_const("resp1", 8'hFF, 8'h08);
    endtask

    task automatic test_loopback();
        do_run(1, 2, -1, 0, "loop");
        check_const("loop", 8'h55, 8'h04);
    endtask

    task automatic test_saturate();
        do_run(40, 1, -1, 1, "sat40");
        n_tests++;
        if (ones !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat40 ones: got %h, want ff", ones);
        end
    endtask

    task automatic test_zero_cycles();
        do_run(0, 1, -1, 0, "zero");
    endtask

    task automatic test_abort();
        do_run(2, 3, 5, 0, "abort5");
        do_run(3, 3, 23, 0, "abort_final");
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        cycles = 8'd5;
        start  = 1'b1;
        resp   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun busy: got %b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({clk3, clk2, clk1, busy, done} !== 5'b0 || sig !== 8'h00 || ones !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_async: clks=%0d busy=%b done=%b sig=%h ones=%h, want all 0",
                     {clk3, clk2, clk1}, busy, done, sig, ones);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || {clk3, clk2, clk1} !== 3'd0) begin
                n_fail++;
                $display("FAIL midrun_after i=%0d: busy=%b done=%b clks=%0d, want 0 0 0",
                         i, busy, done, {clk3, clk2, clk1});
            end
        end
        do_run(1, 1, -1, 0, "fresh");
        check_const("fresh", 8'hFF, 8'h08);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int n;
            int ab;
            n  = int'($urandom_range(1, 6));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8 * n - 1)) : -1;
            do_run(n, 3, ab, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_resp_zero();
        test_resp_one();
        test_loopback();
        test_saturate();
        test_zero_cycles();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the port `start`: input, 1 bit, run request; sampled only in IDLE.
REQ-004 The block SHALL have the port `abort`: input, 1 bit, terminates a run; sampled only in RUN.
REQ-005 The block SHALL have the port `cycles`: input, 8 bits, number of full clk3 periods to generate; latched at start.
REQ-006 The block SHALL have the port `resp`: input, 1 bit, response of the gate network under test; sampled every RUN cycle.
REQ-007 The block SHALL have the port `clk1`: output, 1 bit, stimulus waveform, period 2 clk.
REQ-008 The block SHALL have the port `clk2`: output, 1 bit, stimulus waveform, period 4 clk.
REQ-009 The block SHALL have the port `clk3`: output, 1 bit, stimulus waveform, period 8 clk.
REQ-010 The block SHALL have the port `busy`: output, 1 bit, high while in RUN.
REQ-011 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse at normal completion.
REQ-012 The block SHALL have the port `sig`: output, 8 bits, response signature.
REQ-013 The block SHALL have the port `ones`: output, 8 bits, count of resp=1 samples, saturating.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, DONE.
- IDLE→RUN on start=1 with cycles≠0.
- IDLE→DONE on start=1 with cycles=0.
- RUN→DONE at the final phase wrap.
- RUN→IDLE on abort=1.
- DONE→IDLE unconditionally.
REQ-015 The block SHALL hold a 3-bit phase register ph and drive {clk3,clk2,clk1} = ph directly from flops, with no combinational path to outputs.
REQ-016 On the start edge the block SHALL load cnt=cycles, and clear ph, sig and ones to 0.
REQ-017 In each RUN cycle the block SHALL:
- sample resp, which reflects the ph value currently driven;
- update sig = (sig<<1) ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0,resp};
- increment ones by resp, saturating at 8'hFF;
- increment ph modulo 8.
REQ-018 When ph=7 in RUN, the block SHALL decrement cnt; if cnt=1 at that edge, the next state SHALL be DONE and ph SHALL wrap to 0.
REQ-019 A run SHALL last exactly 8*cycles RUN cycles and take exactly 8*cycles samples; done SHALL be high in the cycle immediately after the last sample edge.
REQ-020 start SHALL be ignored in RUN and DONE; abort SHALL be ignored outside RUN.
REQ-021 If abort and the final wrap occur on the same edge, abort SHALL take priority: the block goes to IDLE, no done pulse, and the final sample is still compressed.
REQ-022 On abort, ph SHALL return to 0 (all stimulus outputs low next cycle); sig and ones SHALL hold their partial values.
REQ-023 sig and ones SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-024 In IDLE and DONE, ph SHALL be 0 and clk1, clk2, clk3 SHALL be 0.
REQ-025 busy SHALL be a registered decode of RUN; done SHALL be a registered decode of DONE.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force the following, regardless of clk: state IDLE, ph=0, cnt=0, sig=0, ones=0, clk1=clk2=clk3=0, busy=0, done=0.
REQ-027 Reset asserted mid-run SHALL abandon the run with no done pulse; after rst_n deasserts, the block SHALL wait for a new start.

Verification
REQ-028 The bench SHALL cover: cycles=1, resp tied 0, pulse start → busy for 8 clk, done pulse once, sig=8'h00, ones=8'h00.
REQ-029 The bench SHALL cover: cycles=1, resp tied 1 → sig=8'hFF, ones=8'h08; clk1/clk2/clk3 show periods 2/4/8 clk during busy.
REQ-030 The bench SHALL cover: cycles=1, resp=clk1 output (loopback) → sig=8'h55, ones=8'h04.
REQ-031 The bench SHALL cover: cycles=40, resp tied 1 → busy for 320 clk, ones saturates at 8'hFF; start pulses during busy have no effect.
REQ-032 The bench SHALL cover: cycles=0 with start → no busy, done pulse on the cycle after start, sig=ones=0.
REQ-033 The bench SHALL cover: abort at RUN cycle 5 of cycles=2, then a separate rst_n pulse mid-run → no done, outputs low, then a fresh run gives the REQ-029 result.
